// File: rtl/regfile_pkg.sv
// Shared constants, clear-engine state type and zero-register index helper
// for the multi-port LEGv8 register file.
package regfile_pkg;

  localparam int DATA_W_DEF = 64;
  localparam int ADDR_W_DEF = 5;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  // Highest entry index; used as the hardwired zero register.
  function automatic int zero_idx(input int addr_w);
    return (1 << addr_w) - 1;
  endfunction

endpackage

// File: rtl/mux_n1.sv
// Word-wide 2**SEL_W:1 multiplexer; one instance per read port selects the
// addressed entry out of the flop array.
module mux_n1 #(
  parameter int W     = 64,
  parameter int SEL_W = 5
) (
  input  logic [2**SEL_W-1:0][W-1:0] din,
  input  logic [SEL_W-1:0]           sel,
  output logic [W-1:0]               dout
);

  assign dout = din[sel];

endmodule

// File: rtl/regfile_np.sv
// NRD-read / 1-write register file with hardwired zero entry, write-to-read
// bypass, optional registered read stage and a one-entry-per-cycle clear sweep.
module regfile_np
  import regfile_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int NRD     = 2,
  parameter bit ZERO_EN = 1'b1,
  parameter bit REG_OUT = 1'b1
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           wr_en,
  input  logic [ADDR_W-1:0]              wr_addr,
  input  logic [DATA_W-1:0]              wr_data,
  input  logic [NRD-1:0]                 rd_en,
  input  logic [NRD-1:0][ADDR_W-1:0]     rd_addr,
  output logic [NRD-1:0][DATA_W-1:0]     rd_data,
  output logic [NRD-1:0]                 rd_valid,
  input  logic                           clr,
  output logic                           busy
);

  localparam int                NREGS = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZIDX  = ADDR_W'(zero_idx(ADDR_W));
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(NREGS - 1);

  logic [NREGS-1:0][DATA_W-1:0] mem;
  state_t                       state;
  logic [ADDR_W-1:0]            ptr;
  logic                         wr_ok;

  assign busy  = (state == CLEAR);
  assign wr_ok = wr_en && !busy && !(ZERO_EN && (wr_addr == ZIDX));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      ptr   <= '0;
    end else if (state == IDLE) begin
      if (clr) state <= CLEAR;
    end else begin
      ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
      if (ptr == LAST) state <= IDLE;
    end
  end

  // The sweep owns the write port while busy, so external writes are dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   mem          <= '0;
    else if (busy)  mem[ptr]     <= '0;
    else if (wr_ok) mem[wr_addr] <= wr_data;
  end

  for (genvar p = 0; p < NRD; p++) begin : g_port
    logic [DATA_W-1:0] mux_out;
    logic [DATA_W-1:0] val;

    mux_n1 #(.W(DATA_W), .SEL_W(ADDR_W)) u_mux (
      .din  (mem),
      .sel  (rd_addr[p]),
      .dout (mux_out)
    );

    always_comb begin
      val = mux_out;
      if (ZERO_EN && (rd_addr[p] == ZIDX))                 val = '0;
      else if (wr_en && !busy && (wr_addr == rd_addr[p])) val = wr_data;
      else if (busy && (rd_addr[p] < ptr))                val = '0;
    end

    if (REG_OUT) begin : g_reg
      logic [DATA_W-1:0] data_q;
      logic              vld_pipe;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          data_q   <= '0;
          vld_pipe <= 1'b0;
        end else begin
          vld_pipe <= rd_en[p];
          if (rd_en[p]) data_q <= val;
        end
      end

      assign rd_data[p]  = data_q;
      assign rd_valid[p] = vld_pipe;
    end else begin : g_comb
      assign rd_data[p]  = val;
      assign rd_valid[p] = rd_en[p];
    end
  end

endmodule

// File: tb/tb_regfile_np.sv
// Bench for regfile_np: a registered-read and a combinational-read instance
// share stimulus and are checked against an array-level reference model.
module tb_regfile_np;

  localparam int DW    = 64;
  localparam int AW    = 5;
  localparam int NRD   = 2;
  localparam int NREGS = 32;

  logic                      clk = 1'b0;
  logic                      reset_n = 1'b0;
  logic                      wr_en = 1'b0;
  logic [AW-1:0]             wr_addr = '0;
  logic [DW-1:0]             wr_data = '0;
  logic [NRD-1:0]            rd_en = '0;
  logic [NRD-1:0][AW-1:0]    rd_addr = '0;
  logic                      clr = 1'b0;
  logic [NRD-1:0][DW-1:0]    rd_data, rd_data_c;
  logic [NRD-1:0]            rd_valid, rd_valid_c;
  logic                      busy, busy_c;

  always #5 clk = ~clk;

  regfile_np #(.DATA_W(DW), .ADDR_W(AW), .NRD(NRD), .ZERO_EN(1'b1), .REG_OUT(1'b1)) u_reg (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .clr(clr), .busy(busy)
  );

  regfile_np #(.DATA_W(DW), .ADDR_W(AW), .NRD(NRD), .ZERO_EN(1'b1), .REG_OUT(1'b0)) u_comb (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_c), .rd_valid(rd_valid_c),
    .clr(clr), .busy(busy_c)
  );

  // Reference model: architectural array contents plus sweep progress.
  logic [DW-1:0]          ref_mem [NREGS];
  bit                     ref_busy;
  int                     ref_pos;
  logic [NRD-1:0][DW-1:0] exp_reg;
  logic [NRD-1:0]         exp_vld;

  int n_chk  = 0;
  int n_fail = 0;

  function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
    if (a == AW'(NREGS - 1)) return '0;
    if (wr_en && !ref_busy && (wr_addr == a)) return wr_data;
    return ref_mem[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) ref_mem[i] = '0;
    ref_busy = 1'b0;
    ref_pos  = 0;
    exp_reg  = '0;
    exp_vld  = '0;
  endtask

  // Advance one clock and apply the architectural effect of the sampled inputs.
  task automatic tick();
    @(posedge clk);
    if (reset_n) begin
      for (int p = 0; p < NRD; p++)
        if (rd_en[p]) exp_reg[p] = ref_read(rd_addr[p]);
      exp_vld = rd_en;
      if (ref_busy) begin
        ref_mem[ref_pos] = '0;
        ref_pos++;
        if (ref_pos == NREGS) begin
          ref_busy = 1'b0;
          ref_pos  = 0;
        end
      end else begin
        if (wr_en && (wr_addr != AW'(NREGS - 1))) ref_mem[wr_addr] = wr_data;
        if (clr) ref_busy = 1'b1;
      end
    end
    #1;
  endtask

  task automatic write(input int a, input logic [DW-1:0] d);
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    model_reset();
    reset_n = 1'b0;
    repeat (3) tick();
    n_chk++;
    if (busy !== 1'b0 || busy_c !== 1'b0) begin
      n_fail++; $display("FAIL reset_busy: got %b/%b want 0", busy, busy_c);
    end
    n_chk++;
    if (rd_valid !== '0 || rd_data !== '0) begin
      n_fail++; $display("FAIL reset_rd: valid %b data %h want 0", rd_valid, rd_data);
    end
    reset_n = 1'b1;
    for (int i = 0; i < NREGS; i++) begin
      rd_en = 2'b11; rd_addr[0] = AW'(i); rd_addr[1] = AW'(NREGS - 1 - i);
      tick();
      n_chk++;
      if (rd_data !== exp_reg || rd_data !== '0 || rd_valid !== 2'b11) begin
        n_fail++; $display("FAIL reset_read[%0d]: got %h v=%b want 0 v=11", i, rd_data, rd_valid);
      end
    end
    rd_en = '0;
    tick();
  endtask

  task automatic test_write_read();
    write(5, 64'hDEADBEEF_00000001);
    rd_en = 2'b01; rd_addr[0] = 5;
    tick();
    rd_en = '0;
    n_chk++;
    if (rd_data[0] !== 64'hDEADBEEF_00000001 || rd_valid[0] !== 1'b1) begin
      n_fail++; $display("FAIL write_read: got %h v=%b want deadbeef00000001 v=1", rd_data[0], rd_valid[0]);
    end
    tick();
    n_chk++;
    if (rd_valid !== 2'b00 || rd_data[0] !== 64'hDEADBEEF_00000001) begin
      n_fail++; $display("FAIL read_hold: got %h v=%b want held data v=00", rd_data[0], rd_valid);
    end
  endtask

  task automatic test_zero_reg();
    write(31, '1);
    rd_en = 2'b11; rd_addr[0] = 31; rd_addr[1] = 31;
    #1;
    n_chk++;
    if (rd_data_c !== '0) begin
      n_fail++; $display("FAIL zero_reg_comb: got %h want 0", rd_data_c);
    end
    tick();
    rd_en = '0;
    n_chk++;
    if (rd_data !== '0 || rd_valid !== 2'b11) begin
      n_fail++; $display("FAIL zero_reg: got %h v=%b want 0 v=11", rd_data, rd_valid);
    end
  endtask

  task automatic test_bypass();
    wr_en = 1'b1; wr_addr = 7; wr_data = 64'h1234;
    rd_en = 2'b11; rd_addr[0] = 7; rd_addr[1] = 7;
    #1;
    n_chk++;
    if (rd_data_c[0] !== 64'h1234 || rd_data_c[1] !== 64'h1234) begin
      n_fail++; $display("FAIL bypass_comb: got %h want 1234 on both", rd_data_c);
    end
    tick();
    wr_en = 1'b0;
    n_chk++;
    if (rd_data[0] !== 64'h1234 || rd_data[1] !== 64'h1234) begin
      n_fail++; $display("FAIL bypass_reg: got %h want 1234 on both", rd_data);
    end
    tick();
    rd_en = '0;
    n_chk++;
    if (rd_data[0] !== 64'h1234 || rd_data[1] !== 64'h1234) begin
      n_fail++; $display("FAIL bypass_stored: got %h want 1234 on both", rd_data);
    end
  endtask

  task automatic test_multiport();
    write(1, 64'hA);
    write(2, 64'hB);
    rd_en = 2'b11; rd_addr[0] = 1; rd_addr[1] = 2;
    tick();
    n_chk++;
    if (rd_data[0] !== 64'hA || rd_data[1] !== 64'hB) begin
      n_fail++; $display("FAIL multiport: got %h want a/b", rd_data);
    end
    rd_addr[0] = 2; rd_addr[1] = 1;
    tick();
    rd_en = '0;
    n_chk++;
    if (rd_data[0] !== 64'hB || rd_data[1] !== 64'hA) begin
      n_fail++; $display("FAIL multiport_swap: got %h want b/a", rd_data);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      wr_en   = 1'($urandom);
      wr_addr = AW'($urandom);
      wr_data = {$urandom, $urandom};
      rd_en   = NRD'($urandom);
      for (int p = 0; p < NRD; p++)
        rd_addr[p] = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom);
      #1;
      for (int p = 0; p < NRD; p++) begin
        n_chk++;
        if (rd_data_c[p] !== ref_read(rd_addr[p]) || rd_valid_c[p] !== rd_en[p]) begin
          n_fail++; $display("FAIL rand_comb[%0d] p%0d: got %h want %h", c, p, rd_data_c[p], ref_read(rd_addr[p]));
        end
      end
      tick();
      n_chk++;
      if (rd_data !== exp_reg || rd_valid !== exp_vld) begin
        n_fail++; $display("FAIL rand_reg[%0d]: got %h v=%b want %h v=%b", c, rd_data, rd_valid, exp_reg, exp_vld);
      end
    end
    wr_en = 1'b0; rd_en = '0;
    tick();
  endtask

  task automatic read_all_zero(input string tag);
    for (int i = 0; i < NREGS; i++) begin
      rd_en = 2'b11; rd_addr[0] = AW'(i); rd_addr[1] = AW'(i);
      tick();
      n_chk++;
      if (rd_data !== '0) begin
        n_fail++; $display("FAIL %s[%0d]: got %h want 0", tag, i, rd_data);
      end
    end
    rd_en = '0;
  endtask

  task automatic test_clear();
    int cnt;
    for (int i = 0; i < NREGS; i++) write(i, {32'hC0DE0000, 32'(i + 1)});
    clr = 1'b1; wr_en = 1'b1; wr_addr = 9; wr_data = 64'h99;
    tick();
    clr = 1'b0; wr_en = 1'b0;
    cnt = 0;
    while (busy && cnt < 100) begin
      cnt++;
      wr_en = (cnt == 3); wr_addr = 4; wr_data = '1;
      rd_en = 2'b11; rd_addr[0] = AW'($urandom); rd_addr[1] = AW'(cnt);
      clr = (cnt == 5);
      #1;
      n_chk++;
      if (busy !== ref_busy || rd_data_c[0] !== ref_read(rd_addr[0]) || rd_data_c[1] !== ref_read(rd_addr[1])) begin
        n_fail++; $display("FAIL sweep_read[%0d]: busy %b data %h want busy %b", cnt, busy, rd_data_c, ref_busy);
      end
      tick();
      wr_en = 1'b0; clr = 1'b0;
      n_chk++;
      if (rd_data !== exp_reg) begin
        n_fail++; $display("FAIL sweep_reg[%0d]: got %h want %h", cnt, rd_data, exp_reg);
      end
    end
    rd_en = '0;
    n_chk++;
    if (cnt != NREGS) begin
      n_fail++; $display("FAIL busy_cycles: got %0d want %0d", cnt, NREGS);
    end
    read_all_zero("clear_read");
  endtask

  task automatic test_reset_mid_sweep();
    for (int i = 0; i < NREGS; i++) write(i, {$urandom | 32'h1, $urandom});
    clr = 1'b1;
    tick();
    clr = 1'b0;
    repeat (9) tick();
    n_chk++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL sweep_active: got busy %b want 1", busy);
    end
    reset_n = 1'b0;
    model_reset();
    #1;
    n_chk++;
    if (busy !== 1'b0 || busy_c !== 1'b0 || rd_valid !== '0) begin
      n_fail++; $display("FAIL reset_abort: busy %b/%b v=%b want 0", busy, busy_c, rd_valid);
    end
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    n_chk++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_abort_idle: got busy %b want 0", busy);
    end
    read_all_zero("abort_read");
  endtask

  task automatic test_comb_read();
    write(3, 64'h55);
    rd_en = 2'b01; rd_addr[0] = 3;
    #1;
    n_chk++;
    if (rd_data_c[0] !== 64'h55 || rd_valid_c !== 2'b01) begin
      n_fail++; $display("FAIL comb_read: got %h v=%b want 55 v=01", rd_data_c[0], rd_valid_c);
    end
    rd_en = 2'b00;
    #1;
    n_chk++;
    if (rd_valid_c !== 2'b00 || rd_data_c[0] !== 64'h55) begin
      n_fail++; $display("FAIL comb_noread: got %h v=%b want 55 v=00", rd_data_c[0], rd_valid_c);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_zero_reg();
    test_bypass();
    test_multiport();
    test_random();
    test_clear();
    test_reset_mid_sweep();
    test_comb_read();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
